// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_ctrl
//  Description : Word-addressed RAM controller with a request/valid handshake.
//                Serves one-word or two-word accesses. A two-word access puts
//                RAM[A] in the low half and RAM[A-1] in the high half. Each
//                word access waits WAIT_STATES extra cycles.
//                Optional macro DATA_MEM_BOUNDS_CHECK_EN enables the address
//                bounds check and the o_fault flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_ctrl #(
  parameter int ADDR_W      = 20,
  parameter int WORD_W      = 16,
  parameter int WAIT_STATES = 0,
  parameter int MEM_TOP     = (2 ** ADDR_W) - 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic                  i_we,
  input  logic                  i_en32,
  input  logic [ADDR_W-1:0]     i_address,
  input  logic [2*WORD_W-1:0]   i_data_in,
  output logic                  o_ready,
  output logic                  o_valid,
  output logic [2*WORD_W-1:0]   o_data_out,
  output logic                  o_busy,
  output logic                  o_fault
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LO   = 2'd1;
  localparam logic [1:0] HI   = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES);

`ifdef DATA_MEM_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  logic [1:0]          state;
  logic [3:0]          wait_cnt;
  logic                req_we;
  logic                req_en32;
  logic [ADDR_W-1:0]   req_addr;
  logic [2*WORD_W-1:0] req_data;
  logic [WORD_W-1:0]   lo_word;
  logic                fault_q;

  logic [WORD_W-1:0]   ram [DEPTH];

  logic                accept;
  logic                last_cycle;
  logic                bad_req;
  logic                ram_wr;
  logic [ADDR_W-1:0]   ram_addr;
  logic [WORD_W-1:0]   ram_rdata;
  logic [WORD_W-1:0]   ram_wdata;

  assign accept     = i_req && (state == IDLE);
  assign last_cycle = (wait_cnt == WAIT_LAST);

  // A > MEM_TOP, or a two-word access at A=0 that would need RAM[-1].
  assign bad_req = BOUNDS_EN &&
                   ((i_address > ADDR_W'(MEM_TOP)) || (i_en32 && (i_address == '0)));

  // The high word lives one address below; the ADDR_W-bit subtraction wraps 0 to DEPTH-1.
  assign ram_addr  = (state == HI) ? (req_addr - ADDR_W'(1)) : req_addr;
  assign ram_rdata = ram[ram_addr];
  assign ram_wdata = (state == HI) ? req_data[2*WORD_W-1:WORD_W] : req_data[WORD_W-1:0];
  assign ram_wr    = req_we && last_cycle && ((state == LO) || (state == HI));

  assign o_ready = (state == IDLE);
  assign o_busy  = (state != IDLE);
  assign o_valid = (state == RESP);
  assign o_fault = fault_q & BOUNDS_EN;

  // RAM array: not reset, so data already written survives a reset.
  always_ff @(posedge clk) begin
    if (ram_wr) begin
      ram[ram_addr] <= ram_wdata;
    end
  end

  // Transaction FSM: capture the request, then wait-count each word phase and build the response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wait_cnt   <= 4'd0;
      req_we     <= 1'b0;
      req_en32   <= 1'b0;
      req_addr   <= '0;
      req_data   <= '0;
      lo_word    <= '0;
      o_data_out <= '0;
      fault_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            req_we   <= i_we;
            req_en32 <= i_en32;
            req_addr <= i_address;
            req_data <= i_data_in;
            wait_cnt <= 4'd0;
            if (bad_req) begin
              state      <= RESP;
              o_data_out <= '0;
              fault_q    <= 1'b1;
            end else begin
              state   <= LO;
              fault_q <= 1'b0;
            end
          end
        end
        LO: begin
          if (last_cycle) begin
            wait_cnt <= 4'd0;
            lo_word  <= ram_rdata;
            if (req_en32) begin
              state <= HI;
            end else begin
              state      <= RESP;
              o_data_out <= req_we ? '0 : {{WORD_W{1'b0}}, ram_rdata};
            end
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        HI: begin
          if (last_cycle) begin
            wait_cnt   <= 4'd0;
            state      <= RESP;
            o_data_out <= req_we ? '0 : {ram_rdata, lo_word};
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem_ctrl
//  Description : Scoreboard bench for data_mem_ctrl. Instance A uses default
//                parameters; instance B uses WAIT_STATES=2 and ADDR_W=8.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_ctrl;

  typedef struct {
    logic [31:0] data;
    logic        fault;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_a = 1'b0;
  logic        req_b = 1'b0;
  logic        we_s = 1'b0;
  logic        en32_s = 1'b0;
  logic [19:0] addr_s = '0;
  logic [31:0] data_s = '0;

  logic        ready_a, valid_a, busy_a, fault_a;
  logic [31:0] dout_a;
  logic        ready_b, valid_b, busy_b, fault_b;
  logic [31:0] dout_b;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t qa[$];
  exp_t qb[$];

  data_mem_ctrl u_dut_a (
    .clk(clk), .rst(rst), .i_req(req_a), .i_we(we_s), .i_en32(en32_s),
    .i_address(addr_s), .i_data_in(data_s), .o_ready(ready_a), .o_valid(valid_a),
    .o_data_out(dout_a), .o_busy(busy_a), .o_fault(fault_a)
  );

  data_mem_ctrl #(.ADDR_W(8), .WORD_W(16), .WAIT_STATES(2)) u_dut_b (
    .clk(clk), .rst(rst), .i_req(req_b), .i_we(we_s), .i_en32(en32_s),
    .i_address(addr_s[7:0]), .i_data_in(data_s), .o_ready(ready_b), .o_valid(valid_b),
    .o_data_out(dout_b), .o_busy(busy_b), .o_fault(fault_b)
  );

  always #5 clk = ~clk;

  // Cycle index used to time-stamp expected responses.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor for instance A.
  always @(negedge clk) begin
    if (valid_a) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_valid", 32'(valid_a), 32'd0);
      end else begin
        exp_t e;
        e = qa.pop_front();
        chk("a_data", dout_a, e.data);
        chk("a_fault", 32'(fault_a), 32'(e.fault));
        chk("a_valid_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Monitor for instance B.
  always @(negedge clk) begin
    if (valid_b) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_valid", 32'(valid_b), 32'd0);
      end else begin
        exp_t e;
        e = qb.pop_front();
        chk("b_data", dout_b, e.data);
        chk("b_fault", 32'(fault_b), 32'(e.fault));
        chk("b_valid_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Wait for the selected instance to be ready, present one request, push its expectation.
  task automatic issue(input bit sel, input bit we, input bit en32, input logic [19:0] addr,
                       input logic [31:0] data, input logic [31:0] exp_data,
                       input bit exp_fault, input int lat);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    while (!(sel ? ready_b : ready_a) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("ready_timeout", 32'd0, 32'd1);
    we_s = we; en32_s = en32; addr_s = addr; data_s = data;
    if (sel) req_b = 1'b1; else req_a = 1'b1;
    e.data = exp_data; e.fault = exp_fault; e.cyc = cyc + lat;
    if (sel) qb.push_back(e); else qa.push_back(e);
    @(negedge clk);
    req_a = 1'b0;
    req_b = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("drain_timeout", 32'(qa.size() + qb.size()), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #2;
    chk("rst_ready", 32'(ready_a), 32'd1);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_valid", 32'(valid_a), 32'd0);
    chk("rst_data", dout_a, 32'd0);
    chk("rst_fault", 32'(fault_a), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Two-word write/read, then the high word alone.
    issue(0, 1, 1, 20'h10, 32'hDEAD_BEEF, 32'h0, 0, 3);
    issue(0, 0, 1, 20'h10, 32'h0, 32'hDEAD_BEEF, 0, 3);
    issue(0, 0, 0, 20'h0F, 32'h0, 32'h0000_DEAD, 0, 2);
    // One-word writes touch only RAM[A].
    issue(0, 1, 0, 20'h1F, 32'h0000_5555, 32'h0, 0, 2);
    issue(0, 1, 0, 20'h20, 32'h1234_ABCD, 32'h0, 0, 2);
    issue(0, 0, 0, 20'h20, 32'h0, 32'h0000_ABCD, 0, 2);
    issue(0, 0, 0, 20'h1F, 32'h0, 32'h0000_5555, 0, 2);
    issue(0, 0, 1, 20'h20, 32'h0, 32'h5555_ABCD, 0, 3);
    // Address 0 two-word read: wraps or faults.
    issue(0, 1, 0, 20'h00000, 32'h0000_7777, 32'h0, 0, 2);
    issue(0, 1, 0, 20'hFFFFF, 32'h0000_9999, 32'h0, 0, 2);
`ifdef DATA_MEM_BOUNDS_CHECK_EN
    issue(0, 0, 1, 20'h00000, 32'h0, 32'h0, 1, 1);
`else
    issue(0, 0, 1, 20'h00000, 32'h0, 32'h9999_7777, 0, 3);
`endif
    drain();

    // Reset during HI of a two-word write: low word persists.
    we_s = 1'b1; en32_s = 1'b1; addr_s = 20'h40; data_s = 32'hCAFE_F00D;
    chk("pre_write_ready", 32'(ready_a), 32'd1);
    req_a = 1'b1;
    @(negedge clk);
    req_a = 1'b0;
    @(negedge clk);
    chk("busy_in_hi", 32'(busy_a), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_ready", 32'(ready_a), 32'd1);
    chk("midrst_busy", 32'(busy_a), 32'd0);
    chk("midrst_valid", 32'(valid_a), 32'd0);
    chk("midrst_data", dout_a, 32'd0);
    chk("midrst_fault", 32'(fault_a), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    issue(0, 0, 0, 20'h40, 32'h0, 32'h0000_F00D, 0, 2);
    drain();

    // i_req held high for 10 cycles: one transaction per IDLE visit.
    begin
      int base;
      exp_t e;
      chk("hold_ready", 32'(ready_a), 32'd1);
      we_s = 1'b0; en32_s = 1'b0; addr_s = 20'h20; data_s = 32'hFFFF_FFFF;
      req_a = 1'b1;
      base = cyc;
      for (int k = 0; k < 4; k++) begin
        e.data = 32'h0000_ABCD; e.fault = 1'b0; e.cyc = base + 2 + 3 * k;
        qa.push_back(e);
      end
      repeat (10) @(negedge clk);
      req_a = 1'b0;
    end
    drain();

    // WAIT_STATES=2 instance: per-cycle handshake profile of a two-word read.
    issue(1, 1, 1, 20'h10, 32'h0BAD_F00D, 32'h0, 0, 7);
    drain();
    begin
      exp_t e;
      chk("b_ready_idle", 32'(ready_b), 32'd1);
      we_s = 1'b0; en32_s = 1'b1; addr_s = 20'h10;
      req_b = 1'b1;
      e.data = 32'h0BAD_F00D; e.fault = 1'b0; e.cyc = cyc + 7;
      qb.push_back(e);
      for (int k = 1; k <= 8; k++) begin
        @(negedge clk);
        chk($sformatf("b_ready_c%0d", k), 32'(ready_b), 32'(k >= 8));
        chk($sformatf("b_busy_c%0d", k), 32'(busy_b), 32'(k <= 7));
        chk($sformatf("b_valid_c%0d", k), 32'(valid_b), 32'(k == 7));
        if (k == 6) req_b = 1'b0;
      end
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
